alu_op_arbiter: RTL and testbench

Shares the single 8-bit ALU between `N_REQ` independent requesters. Each requester presents an opcode and two operands with a valid/ready handshake. The block picks one by round-robin, sequences the ALU through start/done, and returns the result and flags on a common tagged response channel. It sits between the requester-side control logic and the ALU datapath, and is the only master of the ALU's start/operand inputs.

---
 rtl/alu_op_arbiter_pkg.sv | 37 +++
 rtl/alu_op_arbiter_if.sv | 47 ++++
 rtl/alu_op_arbiter_rr_pick.sv | 34 +++
 rtl/alu_op_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_op_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_op_arbiter_pkg.sv
// Shared types for the ALU operation arbiter: opcode and FSM enums,
// flag bit positions and a small index helper.
package alu_arb_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'h0,
        ALU_SUB    = 4'h1,
        ALU_AND    = 4'h2,
        ALU_OR     = 4'h3,
        ALU_XOR    = 4'h4,
        ALU_NOT    = 4'h5,
        ALU_SHL    = 4'h6,
        ALU_SHR    = 4'h7,
        ALU_PASS_A = 4'h8,
        ALU_PASS_B = 4'h9
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Flags travel as {C,Z,N,V}, so C is the MSB.
    localparam int ALU_FLAG_C = 3;
    localparam int ALU_FLAG_Z = 2;
    localparam int ALU_FLAG_N = 1;
    localparam int ALU_FLAG_V = 0;

    localparam logic [15:0] GRANT_CNT_MAX = 16'hFFFF;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/alu_op_arbiter_if.sv
// Bundle of requester, ALU and response signals around the arbiter.
// slave = arbiter side, master = requesters/ALU/consumer side.
interface alu_arb_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) ();
    import alu_arb_pkg::*;

    logic    [N_REQ-1:0]      req_valid;
    logic    [N_REQ-1:0]      req_ready;
    alu_op_t [N_REQ-1:0]      req_op;
    logic    [N_REQ-1:0][7:0] req_a;
    logic    [N_REQ-1:0][7:0] req_b;

    logic                     alu_start;
    alu_op_t                  alu_op;
    logic    [7:0]            alu_a;
    logic    [7:0]            alu_b;
    logic                     alu_done;
    logic    [7:0]            alu_res;
    logic    [3:0]            alu_flags;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic    [ID_W-1:0]       rsp_id;
    logic    [7:0]            rsp_res;
    logic    [3:0]            rsp_flags;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        input  alu_done, alu_res, alu_flags,
        input  rsp_ready,
        output req_ready,
        output alu_start, alu_op, alu_a, alu_b,
        output rsp_valid, rsp_id, rsp_res, rsp_flags
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        output alu_done, alu_res, alu_flags,
        output rsp_ready,
        input  req_ready,
        input  alu_start, alu_op, alu_a, alu_b,
        input  rsp_valid, rsp_id, rsp_res, rsp_flags
    );

endinterface

// File: rtl/alu_op_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, searching upward with wrap.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic             o_any,
    output logic [ID_W-1:0]  o_idx
);

    always_comb begin
        int              w_cand;
        logic [ID_W-1:0] w_cand_idx;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        o_any      = |i_req;
        o_idx      = '0;
        w_cand     = 0;
        w_cand_idx = '0;
        // Walk from the farthest candidate back to the pointer so the closest hit wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_cand = int'(i_ptr) + i;
            if (w_cand >= N_REQ) begin
                w_cand = w_cand - N_REQ;
            end
            w_cand_idx = ID_W'(w_cand);
            if (i_req[w_cand_idx]) begin
                o_idx = w_cand_idx;
            end
        end
    end

endmodule

// File: rtl/alu_op_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between N_REQ requesters.
// Optional per-requester grant counters when ALU_ARB_GRANT_CNT_EN is defined.
module alu_op_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    alu_arb_if.slave                  io_arb
`ifdef ALU_ARB_GRANT_CNT_EN
    ,
    output logic [N_REQ-1:0][15:0]    o_grant_cnt
`endif
);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [ID_W-1:0]  r_gnt;
    alu_op_t          r_op;
    logic [7:0]       r_a;
    logic [7:0]       r_b;
    logic [7:0]       r_res;
    logic [3:0]       r_flags;

    logic             w_pick_any;
    logic [ID_W-1:0]  w_pick_idx;
    logic             w_grant;
    logic             w_done_ok;
    logic             w_rsp_hs;
    logic [N_REQ-1:0] w_req_ready;
    logic             w_alu_start;
    logic             w_rsp_valid;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .i_req (io_arb.req_valid),
        .i_ptr (r_rr_ptr),
        .o_any (w_pick_any),
        .o_idx (w_pick_idx)
    );

    // Gated by rst_n so no requester sees an acceptance that reset would discard.
    assign w_grant   = rst_n && (r_state == ST_IDLE) && w_pick_any;
    assign w_done_ok = (r_state == ST_WAIT) && io_arb.alu_done;
    assign w_rsp_hs  = (r_state == ST_RESP) && io_arb.rsp_ready;

    always_comb begin
        w_next_state = r_state;
        w_req_ready  = '0;
        w_alu_start  = 1'b0;
        w_rsp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_req_ready[w_pick_idx] = 1'b1;
                    w_next_state            = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_alu_start  = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_done_ok) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (w_rsp_hs) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_gnt    <= '0;
            r_op     <= ALU_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_flags  <= '0;
        end else begin
            if (w_grant) begin
                r_gnt <= w_pick_idx;
                r_op  <= io_arb.req_op[w_pick_idx];
                r_a   <= io_arb.req_a[w_pick_idx];
                r_b   <= io_arb.req_b[w_pick_idx];
            end
            if (w_done_ok) begin
                r_res   <= io_arb.alu_res;
                r_flags <= io_arb.alu_flags;
            end
            if (w_rsp_hs) begin
                r_rr_ptr <= ID_W'(wrap_inc(int'(r_gnt), N_REQ));
            end
        end
    end

    assign io_arb.req_ready = w_req_ready;
    assign io_arb.alu_start = w_alu_start;
    assign io_arb.alu_op    = r_op;
    assign io_arb.alu_a     = r_a;
    assign io_arb.alu_b     = r_b;
    assign io_arb.rsp_valid = w_rsp_valid;
    assign io_arb.rsp_id    = r_gnt;
    assign io_arb.rsp_res   = r_res;
    assign io_arb.rsp_flags = r_flags;

`ifdef ALU_ARB_GRANT_CNT_EN
    logic [N_REQ-1:0][15:0] r_grant_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant_cnt <= '0;
        end else if (w_grant && (r_grant_cnt[w_pick_idx] != GRANT_CNT_MAX)) begin
            r_grant_cnt[w_pick_idx] <= r_grant_cnt[w_pick_idx] + 16'd1;
        end
    end

    assign o_grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Directed self-checking bench for alu_op_arbiter: arbitration order,
// ALU sequencing, response stall, mid-operation reset and stray done pulses.
module tb_alu_op_arbiter;
    import alu_arb_pkg::*;

    localparam int N_REQ = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_arb_if #(.N_REQ(N_REQ)) bus ();

`ifdef ALU_ARB_GRANT_CNT_EN
    logic [N_REQ-1:0][15:0] grant_cnt;
`endif

    alu_op_arbiter #(.N_REQ(N_REQ)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_arb (bus)
`ifdef ALU_ARB_GRANT_CNT_EN
        ,
        .o_grant_cnt (grant_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_no   = 0;
    int n_starts = 0;

    logic [7:0] a_tab [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] b_tab [4] = '{8'h01, 8'h02, 8'h03, 8'h04};

    always @(posedge clk) begin
        cyc_no <= cyc_no + 1;
        if (bus.alu_start) n_starts <= n_starts + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_alu_start"}, bus.alu_start, 0);
        check({tag, "_alu_op"},    bus.alu_op,    0);
        check({tag, "_alu_a"},     bus.alu_a,     0);
        check({tag, "_alu_b"},     bus.alu_b,     0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_id"},    bus.rsp_id,    0);
        check({tag, "_rsp_res"},   bus.rsp_res,   0);
        check({tag, "_rsp_flags"}, bus.rsp_flags, 0);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.alu_done  = 1'b0;
        bus.rsp_ready = 1'b0;
        cyc();
        cyc();
        #1;
        check_reset_outs("reset");
        rst_n = 1'b1;
    endtask

    // Called in IDLE with requests already driven; ends back in IDLE after the handshake.
    task automatic serve(input int g, input logic [7:0] a, input int delay,
                         input logic [7:0] res, input logic [3:0] fl,
                         input int stall, input bit drop, output int t_start);
        int starts0;
        #1;
        check("grant_onehot", bus.req_ready, 32'd1 << g);
        starts0 = n_starts;
        cyc();
        if (drop) bus.req_valid[g] = 1'b0;
        bus.alu_done = 1'b0;
        #1;
        check("issue_start", bus.alu_start, 1);
        check("issue_a", bus.alu_a, a);
        check("issue_no_ready", bus.req_ready, 0);
        t_start = cyc_no;
        for (int k = 1; k <= delay; k++) begin
            cyc();
            check("wait_start_low", bus.alu_start, 0);
            check("wait_hold_a", bus.alu_a, a);
        end
        bus.alu_done  = 1'b1;
        bus.alu_res   = res;
        bus.alu_flags = fl;
        cyc();
        bus.alu_done = 1'b0;
        for (int s = 0; s < stall; s++) begin
            check("stall_valid", bus.rsp_valid, 1);
            check("stall_id", bus.rsp_id, g);
            check("stall_res", bus.rsp_res, res);
            check("stall_flags", bus.rsp_flags, fl);
            check("stall_no_ready", bus.req_ready, 0);
            check("stall_no_start", bus.alu_start, 0);
            cyc();
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("rsp_valid", bus.rsp_valid, 1);
        check("rsp_id", bus.rsp_id, g);
        check("rsp_res", bus.rsp_res, res);
        check("rsp_flags", bus.rsp_flags, fl);
        check("rsp_hs_no_ready", bus.req_ready, 0);
        cyc();
        bus.rsp_ready = 1'b0;
        check("one_start", n_starts - starts0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_now;
        int t_prev;
        bus.req_valid = '0;
        bus.alu_done  = 1'b0;
        bus.alu_res   = '0;
        bus.alu_flags = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_op[i] = ALU_ADD;
            bus.req_a[i]  = a_tab[i];
            bus.req_b[i]  = b_tab[i];
        end

        // Single request from requester 2: 0x0F + 0x01 = 0x10, done 2 cycles after start.
        do_reset();
        bus.req_a[2]  = 8'h0F;
        bus.req_b[2]  = 8'h01;
        bus.req_valid = 4'b0100;
        serve(2, 8'h0F, 2, 8'h10, 4'b0000, 0, 1'b1, t_now);
        check("single_op", bus.alu_op, ALU_ADD);
        check("single_b", bus.alu_b, 8'h01);
        check("single_back_idle", bus.rsp_valid, 0);
        bus.req_a[2] = a_tab[2];
        bus.req_b[2] = b_tab[2];

        // All four continuously from reset: order 0,1,2,3,0, issue period 4.
        do_reset();
        bus.req_valid = 4'b1111;
        t_prev = 0;
        for (int n = 0; n < 5; n++) begin
            serve(n % 4, a_tab[n % 4], 1, 8'h50 + 8'(n), 4'b0001, 0, 1'b0, t_now);
            if (n > 0) check("issue_period", t_now - t_prev, 4);
            t_prev = t_now;
        end

        // Requester 1 granted (ptr=1), response stalled 5 cycles while 3 waits.
        bus.req_valid = 4'b1010;
        serve(1, a_tab[1], 1, 8'h7E, 4'b0010, 5, 1'b1, t_now);
        #1;
        check("after_hs_grant3", bus.req_ready, 4'b1000);

        // Requester 3 is granted now; reset it in WAIT, then a stray done.
        cyc();
        bus.req_valid = 4'b0101;
        cyc();
        rst_n = 1'b0;
        cyc();
        check_reset_outs("midreset");
        rst_n         = 1'b1;
        bus.alu_done  = 1'b1;
        bus.alu_res   = 8'hEE;
        bus.alu_flags = 4'b1111;
        #1;
        check("postreset_rsp_valid", bus.rsp_valid, 0);
        serve(0, a_tab[0], 1, 8'h21, 4'b0000, 0, 1'b1, t_now);
        bus.req_valid = '0;

        // Spurious done in IDLE and ISSUE; only the WAIT-phase value is returned.
        bus.alu_done  = 1'b1;
        bus.alu_res   = 8'hAA;
        bus.alu_flags = 4'b0100;
        #1;
        check("spur_idle_start", bus.alu_start, 0);
        cyc();
        check("spur_idle_rsp", bus.rsp_valid, 0);
        check("spur_idle_nostart", bus.alu_start, 0);
        bus.req_op[1] = ALU_SUB;
        bus.req_a[1]  = 8'h30;
        bus.req_b[1]  = 8'h10;
        bus.req_valid = 4'b0010;
        bus.alu_res   = 8'hBB;
        #1;
        check("spur_grant", bus.req_ready, 4'b0010);
        cyc();
        bus.req_valid = '0;
        bus.alu_res   = 8'hCC;
        #1;
        check("spur_issue_start", bus.alu_start, 1);
        check("spur_issue_op", bus.alu_op, ALU_SUB);
        cyc();
        bus.alu_done = 1'b0;
        #1;
        check("spur_issue_ignored", bus.rsp_valid, 0);
        cyc();
        bus.alu_done  = 1'b1;
        bus.alu_res   = 8'h20;
        bus.alu_flags = 4'b1000;
        cyc();
        bus.alu_done = 1'b0;
        check("spur_rsp_valid", bus.rsp_valid, 1);
        check("spur_rsp_id", bus.rsp_id, 1);
        check("spur_rsp_res", bus.rsp_res, 8'h20);
        check("spur_rsp_flags", bus.rsp_flags, 4'b1000);
        bus.rsp_ready = 1'b1;
        cyc();
        bus.rsp_ready = 1'b0;
        check("spur_done", bus.rsp_valid, 0);

`ifdef ALU_ARB_GRANT_CNT_EN
        do_reset();
        for (int n = 0; n < 3; n++) begin
            bus.req_valid = 4'b0010;
            serve(1, 8'h30, 1, 8'h01, 4'b0000, 0, 1'b1, t_now);
        end
        check("cnt_1", grant_cnt[1], 3);
        check("cnt_0", grant_cnt[0], 0);
        check("cnt_2", grant_cnt[2], 0);
        check("cnt_3", grant_cnt[3], 0);
        force dut.r_grant_cnt = {16'd0, 16'd0, 16'hFFFF, 16'd0};
        cyc();
        release dut.r_grant_cnt;
        bus.req_valid = 4'b0010;
        serve(1, 8'h30, 1, 8'h01, 4'b0000, 0, 1'b1, t_now);
        check("cnt_sat", grant_cnt[1], 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
